morse_keyer: RTL and testbench

//  Parametrised Morse sequencer. Buffers ASCII characters from the UART receive

---
 rtl/morse_keyer_if.sv | 10 +
 rtl/morse_keyer.sv | 223 ++++++++++++++++++++++
 tb/tb_morse_keyer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_keyer_if.sv
// Character handshake into the Morse keyer: producer drives valid/data,
// the keyer answers with ready.
interface morse_keyer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/morse_keyer.sv
// Buffers ASCII characters in a circular FIFO and keys them out as Morse
// on/off timing, echoing each character as its keying begins.
module morse_keyer #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned UNIT_W   = 24,
  parameter int unsigned CHAR_GAP = 3,
  parameter int unsigned WORD_GAP = 7
) (
  input  logic                   clk_24,
  input  logic                   rst_n,
  morse_keyer_if.slave           in_bus,
  input  logic [UNIT_W-1:0]      unit_cycles,
  input  logic                   flush,
  output logic                   key_out,
  output logic                   echo_valid,
  output logic [7:0]             echo_data,
  output logic                   bad_char,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned GW = $clog2(WORD_GAP + 4);

  typedef enum logic [2:0] {IDLE, FETCH, MARK, ESPACE, GAP} state_t;

  state_t            state, state_d;
  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        rd_data;
  logic              full, empty, push, pop;

  logic [UNIT_W-1:0] unit_cnt, cnt_d;
  logic [UNIT_W-1:0] unit_len, len_d;
  logic [GW-1:0]     units, units_d;
  logic [5:0]        pat, pat_d;
  logic [2:0]        elems, elems_d;
  logic              tick;
  logic              key_d, echo_valid_d, bad_d;
  logic [7:0]        echo_data_d;

  logic [5:0]        fetch_pat;
  logic [2:0]        fetch_len;
  logic              fetch_space;

  // ---------------------------------------------------------------- FIFO
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign pop     = (state == FETCH) && !flush;
  // A pop frees a slot this cycle, so a full FIFO still takes a write alongside it.
  assign in_bus.in_ready = !full || pop;
  assign push    = in_bus.in_valid && in_bus.in_ready && !flush;
  assign busy    = (state != IDLE) || !empty;

  always_ff @(posedge clk_24) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_bus.in_data;
  end

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------- lookup
  // Returns {pattern, length}; bit i of pattern set = element i is a dash.
  // Length 0 marks an unmappable character.
  function automatic logic [8:0] morse_code(input logic [7:0] ch);
    logic [7:0] up;
    up = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    case (up)
      "A": morse_code = {6'b000010, 3'd2};
      "B": morse_code = {6'b000001, 3'd4};
      "C": morse_code = {6'b000101, 3'd4};
      "D": morse_code = {6'b000001, 3'd3};
      "E": morse_code = {6'b000000, 3'd1};
      "F": morse_code = {6'b000100, 3'd4};
      "G": morse_code = {6'b000011, 3'd3};
      "H": morse_code = {6'b000000, 3'd4};
      "I": morse_code = {6'b000000, 3'd2};
      "J": morse_code = {6'b001110, 3'd4};
      "K": morse_code = {6'b000101, 3'd3};
      "L": morse_code = {6'b000010, 3'd4};
      "M": morse_code = {6'b000011, 3'd2};
      "N": morse_code = {6'b000001, 3'd2};
      "O": morse_code = {6'b000111, 3'd3};
      "P": morse_code = {6'b000110, 3'd4};
      "Q": morse_code = {6'b001011, 3'd4};
      "R": morse_code = {6'b000010, 3'd3};
      "S": morse_code = {6'b000000, 3'd3};
      "T": morse_code = {6'b000001, 3'd1};
      "U": morse_code = {6'b000100, 3'd3};
      "V": morse_code = {6'b001000, 3'd4};
      "W": morse_code = {6'b000110, 3'd3};
      "X": morse_code = {6'b001001, 3'd4};
      "Y": morse_code = {6'b001101, 3'd4};
      "Z": morse_code = {6'b000011, 3'd4};
      "0": morse_code = {6'b011111, 3'd5};
      "1": morse_code = {6'b011110, 3'd5};
      "2": morse_code = {6'b011100, 3'd5};
      "3": morse_code = {6'b011000, 3'd5};
      "4": morse_code = {6'b010000, 3'd5};
      "5": morse_code = {6'b000000, 3'd5};
      "6": morse_code = {6'b000001, 3'd5};
      "7": morse_code = {6'b000011, 3'd5};
      "8": morse_code = {6'b000111, 3'd5};
      "9": morse_code = {6'b001111, 3'd5};
      default: morse_code = '0;
    endcase
  endfunction

  assign {fetch_pat, fetch_len} = morse_code(rd_data);
  assign fetch_space = (rd_data == 8'h20);

  // ---------------------------------------------------------------- FSM
  assign tick = (unit_cnt == unit_len - UNIT_W'(1));

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      unit_len   <= UNIT_W'(1);
      units      <= '0;
      pat        <= '0;
      elems      <= '0;
      key_out    <= 1'b0;
      echo_valid <= 1'b0;
      echo_data  <= '0;
      bad_char   <= 1'b0;
    end else begin
      state      <= state_d;
      unit_cnt   <= cnt_d;
      unit_len   <= len_d;
      units      <= units_d;
      pat        <= pat_d;
      elems      <= elems_d;
      key_out    <= key_d;
      echo_valid <= echo_valid_d;
      echo_data  <= echo_data_d;
      bad_char   <= bad_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = unit_cnt + UNIT_W'(1);
    len_d        = unit_len;
    units_d      = units;
    pat_d        = pat;
    elems_d      = elems;
    echo_valid_d = 1'b0;
    echo_data_d  = echo_data;
    bad_d        = 1'b0;

    unique case (state)
      IDLE: if (!empty) state_d = FETCH;
      FETCH: begin
        len_d = (unit_cycles == '0) ? UNIT_W'(1) : unit_cycles;
        if (fetch_len != '0) begin
          state_d      = MARK;
          pat_d        = fetch_pat;
          elems_d      = fetch_len;
          units_d      = fetch_pat[0] ? GW'(3) : GW'(1);
          echo_valid_d = 1'b1;
          echo_data_d  = rd_data;
        end else if (fetch_space) begin
          state_d      = GAP;
          units_d      = GW'(WORD_GAP - CHAR_GAP);
          echo_valid_d = 1'b1;
          echo_data_d  = rd_data;
        end else begin
          state_d = IDLE;
          bad_d   = 1'b1;
        end
      end
      MARK: if (tick) begin
        if (units != GW'(1)) begin
          units_d = units - GW'(1);
        end else if (elems != 3'd1) begin
          state_d = ESPACE;
          units_d = GW'(1);
          pat_d   = pat >> 1;
          elems_d = elems - 3'd1;
        end else begin
          state_d = GAP;
          units_d = GW'(CHAR_GAP);
        end
      end
      ESPACE: if (tick) begin
        state_d = MARK;
        units_d = pat[0] ? GW'(3) : GW'(1);
      end
      GAP: if (tick) begin
        if (units != GW'(1)) units_d = units - GW'(1);
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Restarting the count on every state entry keeps each state a whole number of units.
    if (tick || (state_d != state) || (state == IDLE) || (state == FETCH)) cnt_d = '0;

    if (flush) begin
      state_d      = IDLE;
      cnt_d        = '0;
      echo_valid_d = 1'b0;
      echo_data_d  = echo_data;
      bad_d        = 1'b0;
    end

    key_d = (state_d == MARK);
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Randomized and directed bench for morse_keyer against a timeline model built
// from Morse dot/dash strings.
module tb_morse_keyer;
  localparam int unsigned CHAR_GAP = 3;
  localparam int unsigned WORD_GAP = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [23:0] unit_cycles;
  logic        key_out, echo_valid, bad_char, busy;
  logic [7:0]  echo_data;
  logic [6:0]  level;

  morse_keyer_if bus ();

  morse_keyer #(.DEPTH(64), .UNIT_W(24), .CHAR_GAP(CHAR_GAP), .WORD_GAP(WORD_GAP)) dut (
    .clk_24      (clk),
    .rst_n       (rst_n),
    .in_bus      (bus),
    .unit_cycles (unit_cycles),
    .flush       (flush),
    .key_out     (key_out),
    .echo_valid  (echo_valid),
    .echo_data   (echo_data),
    .bad_char    (bad_char),
    .busy        (busy),
    .level       (level)
  );

  always #20 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  string LETTERS [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string DIGITS [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  typedef struct {
    bit         key;
    bit         echo;
    bit         bad;
    bit         busy;
    logic [7:0] ch;
  } cyc_t;

  cyc_t       exp_q[$];
  bit         pend_echo, pend_bad;
  logic [7:0] pend_ch;

  function automatic string morse_of(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= "a" && u <= "z") u = u - 8'd32;
    if (u >= "A" && u <= "Z") return LETTERS[u - 8'd65];
    if (u >= "0" && u <= "9") return DIGITS[u - 8'd48];
    return "";
  endfunction

  function automatic int unsigned eff_unit(input int unsigned u);
    return (u == 0) ? 1 : u;
  endfunction

  task automatic add(input bit key, input bit bsy, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cyc_t c;
      c.key  = key;
      c.busy = bsy;
      c.echo = pend_echo;
      c.bad  = pend_bad;
      c.ch   = pend_ch;
      pend_echo = 0;
      pend_bad  = 0;
      exp_q.push_back(c);
    end
  endtask

  // Every character costs one IDLE and one FETCH cycle before its keyed
  // timing; strobes appear on the cycle after FETCH.
  task automatic build(input string s, input int unsigned u_first, input int unsigned u_rest);
    exp_q.delete();
    pend_echo = 0;
    pend_bad  = 0;
    pend_ch   = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0]  c;
      string       m;
      int unsigned u;
      c = s[i];
      m = morse_of(c);
      u = (i == 0) ? u_first : u_rest;
      add(0, 1, 2);
      if (c == 8'h20) begin
        pend_echo = 1;
        pend_ch   = c;
        add(0, 1, (WORD_GAP - CHAR_GAP) * u);
      end else if (m.len() == 0) begin
        pend_bad = 1;
      end else begin
        pend_echo = 1;
        pend_ch   = c;
        for (int e = 0; e < m.len(); e++) begin
          add(1, 1, (m[e] == "-") ? 3 * u : u);
          if (e != m.len() - 1) add(0, 1, u);
        end
        add(0, 1, CHAR_GAP * u);
      end
    end
    add(0, 0, 4);
  endtask

  // Writes s on consecutive cycles; unit_cycles switches from u0 to u1 while
  // the first character is already keying.
  task automatic run(input string s, input int unsigned u0, input int unsigned u1, input string tag);
    build(s, eff_unit(u0), eff_unit(u1));
    @(negedge clk);
    unit_cycles = 24'(u0);
    fork
      begin
        for (int i = 0; i < s.len(); i++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = s[i];
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        for (int n = 0; n < exp_q.size(); n++) begin
          if (n == 3) unit_cycles = 24'(u1);
          check({tag, ":wave"}, {key_out, echo_valid, bad_char, busy},
                {exp_q[n].key, exp_q[n].echo, exp_q[n].bad, exp_q[n].busy});
          if (exp_q[n].echo) check({tag, ":echo_data"}, echo_data, exp_q[n].ch);
          @(negedge clk);
        end
      end
    join
    check({tag, ":level"}, level, 0);
  endtask

  task automatic start_dash();
    @(negedge clk);
    unit_cycles  = 24'd4;
    bus.in_valid = 1'b1;
    bus.in_data  = "T";
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !key_out; i++) @(negedge clk);
    check("dash:up", key_out, 1);
    repeat (5) @(negedge clk);
    check("dash:mid", key_out, 1);
  endtask

  initial begin
    string ALPH;
    int unsigned acc, rw, lvl_bad, seen, key_seen;
    ALPH = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789  #!?";

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    unit_cycles  = 24'd4;
    repeat (3) @(negedge clk);
    check("rst:in_ready", bus.in_ready, 1);
    check("rst:outs", {key_out, echo_valid, bad_char, busy}, 0);
    check("rst:echo_data", echo_data, 0);
    check("rst:level", level, 0);
    rst_n = 1'b1;

    run("E",   4, 4, "E");
    run("a",   4, 4, "a");
    run("E E", 4, 4, "E_space_E");
    run("#E",  4, 4, "bad_then_E");
    run("T",   0, 0, "zero_unit");
    run("AB",  2, 5, "unit_switch");

    for (int r = 0; r < 10; r++) begin
      string s;
      int unsigned len;
      s   = "";
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        s = {s, " "};
        s[i] = ALPH[$urandom_range(0, ALPH.len() - 1)];
      end
      run(s, $urandom_range(0, 5), $urandom_range(0, 5), $sformatf("rand%0d", r));
    end

    // Fill: the first character leaves the FIFO at once on FETCH, so 65
    // writes are taken before the FIFO holds 64 and refuses the next.
    @(negedge clk);
    unit_cycles = 24'd1000;
    acc = 0;
    for (int i = 0; i < 66; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? 8'h45 : 8'h4b;
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    check("full:accepted", acc, 65);
    check("full:in_ready", bus.in_ready, 0);
    check("full:level", level, 64);
    bus.in_data = "Z";
    rw = 0; lvl_bad = 0; seen = 0;
    for (int i = 0; i < 6000 && seen == 0; i++) begin
      if (level != 7'd64) lvl_bad++;
      if (bus.in_ready) begin
        rw++;
        seen = 1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("full:rw_seen", seen, 1);
    check("full:rw_level", level, 64);
    check("full:level_held", lvl_bad, 0);
    check("full:rw_echo", {echo_valid, echo_data}, {1'b1, 8'h4b});
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("full:flush_level", level, 0);
    check("full:flush_outs", {key_out, busy}, 0);

    // Flush mid-dash, with a same-cycle write that must be lost.
    start_dash();
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = "E";
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush:key", key_out, 0);
    check("flush:level", level, 0);
    check("flush:busy", busy, 0);
    key_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (key_out || busy) key_seen++;
    end
    check("flush:quiet", key_seen, 0);
    run("E", 4, 4, "after_flush");

    // Asynchronous reset mid-dash.
    start_dash();
    #5 rst_n = 1'b0;
    #1;
    check("areset:key", key_out, 0);
    check("areset:level", level, 0);
    check("areset:busy", busy, 0);
    check("areset:echo_data", echo_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("T", 4, 4, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
